// File: rtl/clkdiv_ctrl.sv
// Runtime-programmable 50%-duty clock divider with start/stop control and a
// one-deep divisor mailbox that only takes effect at a period boundary.
module clkdiv_ctrl #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             out,
    output logic             tick,
    output logic             running,
    output logic [WIDTH-1:0] div_cur,
    output logic [1:0]       fsm_state
);

    // Handshake: a divisor transfers on any rising edge where div_valid and
    // div_ready are both high; div_ready falls on the following cycle and stays
    // low until the held divisor has been applied. div_valid is ignored while
    // div_ready is low.

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);
    localparam logic [WIDTH-1:0] DEF_RAW = WIDTH'(DEFAULT_DIV);

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] pend_div;
    logic             pend_valid;
    logic [WIDTH-1:0] half;
    logic             toggle;

    // Odd divisors round down to even; anything below 2 clamps to 2.
    function automatic logic [WIDTH-1:0] sanitize(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] e;
        e = d & ~ONE;
        if (e < TWO) begin
            e = TWO;
        end
        return e;
    endfunction

    assign half      = div_cur >> 1;
    assign toggle    = (cnt >= half);
    assign div_ready = ~pend_valid;
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            out        <= 1'b0;
            tick       <= 1'b0;
            running    <= 1'b0;
            cnt        <= '0;
            div_cur    <= sanitize(DEF_RAW);
            pend_div   <= '0;
            pend_valid <= 1'b0;
        end else begin
            tick <= 1'b0;

            if (div_valid && !pend_valid) begin
                pend_div   <= sanitize(div_in);
                pend_valid <= 1'b1;
            end

            case (state)
                IDLE: begin
                    out <= 1'b0;
                    if (pend_valid) begin
                        div_cur    <= pend_div;
                        pend_valid <= 1'b0;
                    end
                    if (en) begin
                        state   <= RUN;
                        cnt     <= ONE;
                        running <= 1'b1;
                    end else begin
                        cnt <= '0;
                    end
                end

                RUN, STOPPING: begin
                    if (!en && !out) begin
                        // Low phase can be cut short without producing a runt.
                        state   <= IDLE;
                        cnt     <= '0;
                        running <= 1'b0;
                    end else if (toggle) begin
                        out  <= ~out;
                        cnt  <= ONE;
                        tick <= ~out;
                        if (out) begin
                            // Falling edge closes the period: the only safe apply point.
                            if (pend_valid) begin
                                div_cur    <= pend_div;
                                pend_valid <= 1'b0;
                            end
                            if (!en) begin
                                state   <= IDLE;
                                cnt     <= '0;
                                running <= 1'b0;
                            end else begin
                                state <= RUN;
                            end
                        end else begin
                            state <= RUN;
                        end
                    end else begin
                        cnt   <= cnt + ONE;
                        state <= en ? RUN : STOPPING;
                    end
                end

                default: begin
                    state   <= IDLE;
                    out     <= 1'b0;
                    cnt     <= '0;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed bench for clkdiv_ctrl: cycle-by-cycle vector table plus hand-written
// sequences for the long half-period and asynchronous reset corners.
module tb_clkdiv_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [W-1:0] div_in = '0;
    logic         div_valid = 1'b0;
    logic         div_ready;
    logic         out;
    logic         tick;
    logic         running;
    logic [W-1:0] div_cur;
    logic [1:0]   fsm_state;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic         en;
        logic [W-1:0] div;
        logic         valid;
        logic         o;
        logic         t;
        logic         r;
        logic         rdy;
        logic [W-1:0] cur;
    } vec_t;

    vec_t vecs[$];

    clkdiv_ctrl #(.WIDTH(W), .DEFAULT_DIV(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .div_in    (div_in),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .out       (out),
        .tick      (tick),
        .running   (running),
        .div_cur   (div_cur),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic [W-1:0] d, input logic v,
                       input logic o, input logic t, input logic r,
                       input logic rdy, input logic [W-1:0] cur);
        vec_t x;
        x.en = e; x.div = d; x.valid = v;
        x.o = o; x.t = t; x.r = r; x.rdy = rdy; x.cur = cur;
        vecs.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;

        // div 2 free-running, then stop from low phase
        add(1,0,0, 0,0,1,1,2); add(1,0,0, 1,1,1,1,2); add(1,0,0, 0,0,1,1,2);
        add(1,0,0, 1,1,1,1,2); add(1,0,0, 0,0,1,1,2); add(0,0,0, 0,0,0,1,2);
        // load 7 in IDLE -> 6, run 3/3
        add(0,7,1, 0,0,0,0,2); add(0,0,0, 0,0,0,1,6);
        add(1,0,0, 0,0,1,1,6); add(1,0,0, 0,0,1,1,6); add(1,0,0, 0,0,1,1,6);
        add(1,0,0, 1,1,1,1,6); add(1,0,0, 1,0,1,1,6); add(1,0,0, 1,0,1,1,6);
        add(1,0,0, 0,0,1,1,6); add(1,0,0, 0,0,1,1,6); add(1,0,0, 0,0,1,1,6);
        add(1,0,0, 1,1,1,1,6);
        // drop en in high phase with cnt=1: two more high cycles, then idle
        add(0,0,0, 1,0,1,1,6); add(0,0,0, 1,0,1,1,6); add(0,0,0, 0,0,0,1,6);
        add(0,0,0, 0,0,0,1,6);
        // drop en in low phase: idle on the next edge
        add(1,0,0, 0,0,1,1,6); add(1,0,0, 0,0,1,1,6); add(0,0,0, 0,0,0,1,6);
        add(0,0,0, 0,0,0,1,6);
        // stop cancelled while STOPPING
        add(1,0,0, 0,0,1,1,6); add(1,0,0, 0,0,1,1,6); add(1,0,0, 0,0,1,1,6);
        add(1,0,0, 1,1,1,1,6); add(0,0,0, 1,0,1,1,6); add(1,0,0, 1,0,1,1,6);
        add(1,0,0, 0,0,1,1,6); add(1,0,0, 0,0,1,1,6); add(0,0,0, 0,0,0,1,6);
        add(0,0,0, 0,0,0,1,6);
        // div 8, load 4 mid-high: change lands at the falling edge
        add(0,8,1, 0,0,0,0,6); add(0,0,0, 0,0,0,1,8);
        add(1,0,0, 0,0,1,1,8); add(1,0,0, 0,0,1,1,8); add(1,0,0, 0,0,1,1,8);
        add(1,0,0, 0,0,1,1,8); add(1,0,0, 1,1,1,1,8);
        add(1,4,1, 1,0,1,0,8); add(1,0,0, 1,0,1,0,8); add(1,0,0, 1,0,1,0,8);
        add(1,0,0, 0,0,1,1,4); add(1,0,0, 0,0,1,1,4); add(1,0,0, 1,1,1,1,4);
        add(1,0,0, 1,0,1,1,4);
        // accept on the period-end edge defers apply; busy div_valid ignored;
        // stop completion and apply coincide
        add(1,6,1, 0,0,1,0,4); add(1,10,1, 0,0,1,0,4); add(1,0,0, 1,1,1,0,4);
        add(0,0,0, 1,0,1,0,4); add(0,0,0, 0,0,0,1,6);
        // sanitizing corners
        add(0,0,1, 0,0,0,0,6); add(0,0,0, 0,0,0,1,2);
        add(0,5,1, 0,0,0,0,2); add(0,0,0, 0,0,0,1,4);
        add(0,1,1, 0,0,0,0,4); add(0,0,0, 0,0,0,1,2);
        add(0,16'hFFFF,1, 0,0,0,0,2); add(0,0,0, 0,0,0,1,16'hFFFE);

        // reset state while rst_n is held low
        #12;
        check("rst.out", out, 1'b0);
        check("rst.tick", tick, 1'b0);
        check("rst.running", running, 1'b0);
        check("rst.div_ready", div_ready, 1'b1);
        check("rst.div_cur", div_cur, 16'd2);
        check("rst.state", fsm_state, 2'd0);
        #11;
        rst_n = 1'b1;
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            en = vecs[i].en;
            div_in = vecs[i].div;
            div_valid = vecs[i].valid;
            step();
            check($sformatf("vec%0d.out", i), out, vecs[i].o);
            check($sformatf("vec%0d.tick", i), tick, vecs[i].t);
            check($sformatf("vec%0d.running", i), running, vecs[i].r);
            check($sformatf("vec%0d.div_ready", i), div_ready, vecs[i].rdy);
            check($sformatf("vec%0d.div_cur", i), div_cur, vecs[i].cur);
        end

        // divisor 0xFFFE: first rise 32767 edges after the edge sampling en
        en = 1'b1;
        div_valid = 1'b0;
        step();
        check("big.running", running, 1'b1);
        check("big.out_low", out, 1'b0);
        n = 0;
        for (int k = 1; k <= 40000; k++) begin
            step();
            if (out) begin
                n = k;
                break;
            end
        end
        check("big.rise_latency", n, 32767);
        check("big.tick", tick, 1'b1);

        // async reset mid high phase with a divisor pending
        div_in = 16'd10;
        div_valid = 1'b1;
        step();
        check("ar.pending_ready", div_ready, 1'b0);
        check("ar.still_high", out, 1'b1);
        div_valid = 1'b0;
        en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.out_async", out, 1'b0);
        check("ar.running_async", running, 1'b0);
        #3;
        rst_n = 1'b1;
        step();
        check("ar.div_cur", div_cur, 16'd2);
        check("ar.div_ready", div_ready, 1'b1);
        step();
        check("ar.pending_dropped", div_cur, 16'd2);

        // default divisor runs again after reset
        en = 1'b1;
        step();
        check("post.out0", out, 1'b0);
        step();
        check("post.out1", out, 1'b1);
        check("post.tick1", tick, 1'b1);
        step();
        check("post.out2", out, 1'b0);
        check("post.tick2", tick, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
